// File: rtl/fir_xifu_ctrl.sv
// rtl/fir_xifu_ctrl.sv - FIR XIFU operand/hazard controller
//
// Owns the XIFU register file and a per-register write scoreboard. Stalls the
// ID stage on RAW/WAW hazards and registers operands for EX on issue.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   id_valid_i/id_ready_o    ID handshake (issue = valid & ready)
//   id_instr_i               00 XFIRLW, 01 XFIRSW, 10 XFIRDOTP, 11 INVALID
//   id_rs1_i/rs2_i/rd_i      register indices, id_id_i instruction ID
//   op_a_o/op_b_o/op_c_o     operands to EX, ex_valid_o one-cycle strobe
//   wb_valid_i/rd_i/data_i   register file write from WB
//   commit_valid_i/id_i/kill_i  X-interface commit channel

module fir_xifu_ctrl #(
  parameter int NrRegs  = 32,
  parameter int IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [1:0]         id_instr_i,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic [4:0]         id_rd_i,
  input  logic [IdWidth-1:0] id_id_i,
  output logic [31:0]        op_a_o,
  output logic [31:0]        op_b_o,
  output logic [31:0]        op_c_o,
  output logic               ex_valid_o,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [31:0]        wb_data_i,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i
);

  typedef enum logic [1:0] {
    INSTR_LW      = 2'b00,
    INSTR_SW      = 2'b01,
    INSTR_DOTP    = 2'b10,
    INSTR_INVALID = 2'b11
  } instr_e;

  logic [31:0]        rf_q    [NrRegs];
  logic [IdWidth-1:0] owner_q [NrRegs];
  logic [NrRegs-1:0]  pending_q;
  logic [NrRegs-1:0]  pending_d;
  logic [NrRegs-1:0]  wb_hit;
  logic [NrRegs-1:0]  kill_hit;
  logic [NrRegs-1:0]  busy;

  logic reads_rs1, reads_rs2, reads_rd, writes_rd;
  logic issue;
  logic [31:0] op_a_d, op_b_d, op_c_d;

  // Current-cycle WB is forwarded to operand reads.
  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (wb_valid_i && (wb_rd_i == idx)) begin
      return wb_data_i;
    end
    return rf_q[idx];
  endfunction

  always_comb begin
    wb_hit   = '0;
    kill_hit = '0;
    for (int r = 0; r < NrRegs; r++) begin
      wb_hit[r]   = wb_valid_i && (wb_rd_i == 5'(r));
      kill_hit[r] = commit_valid_i && commit_kill_i && pending_q[r] &&
                    (owner_q[r] == commit_id_i);
    end
  end

  // WB clears are bypassed into the hazard check; kills are not, so a
  // killed dependency releases its waiters one cycle later.
  assign busy = pending_q & ~wb_hit;

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    reads_rd  = 1'b0;
    writes_rd = 1'b0;
    case (instr_e'(id_instr_i))
      INSTR_LW:   writes_rd = 1'b1;
      INSTR_SW:   reads_rs2 = 1'b1;
      INSTR_DOTP: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        reads_rd  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign id_ready_o = (id_instr_i != INSTR_INVALID) &&
                      !(reads_rs1 && busy[id_rs1_i]) &&
                      !(reads_rs2 && busy[id_rs2_i]) &&
                      !((reads_rd || writes_rd) && busy[id_rd_i]);

  assign issue = id_valid_i && id_ready_o;

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    op_c_d = '0;
    if (reads_rs1) begin
      op_a_d = read_reg(id_rs1_i);
    end else if (reads_rs2) begin
      op_a_d = read_reg(id_rs2_i);
    end
    if (reads_rs1 && reads_rs2) begin
      op_b_d = read_reg(id_rs2_i);
    end
    if (reads_rd) begin
      op_c_d = read_reg(id_rd_i);
    end
  end

  // Clears first, then a same-cycle issue re-sets its destination.
  always_comb begin
    pending_d = pending_q & ~kill_hit & ~wb_hit;
    if (issue && writes_rd) begin
      pending_d[id_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      ex_valid_o <= 1'b0;
      op_a_o     <= '0;
      op_b_o     <= '0;
      op_c_o     <= '0;
      for (int r = 0; r < NrRegs; r++) begin
        rf_q[r]    <= '0;
        owner_q[r] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      ex_valid_o <= issue;
      if (issue) begin
        op_a_o <= op_a_d;
        op_b_o <= op_b_d;
        op_c_o <= op_c_d;
        if (writes_rd) begin
          owner_q[id_rd_i] <= id_id_i;
        end
      end
      if (wb_valid_i) begin
        rf_q[wb_rd_i] <= wb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// tb/tb_fir_xifu_ctrl.sv - self-checking bench for fir_xifu_ctrl
module tb_fir_xifu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [1:0]  id_instr_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]  id_id_i;
  logic [31:0] op_a_o, op_b_o, op_c_o;
  logic        ex_valid_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;

  fir_xifu_ctrl #(.NrRegs(32), .IdWidth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_id_i(id_id_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o), .ex_valid_o(ex_valid_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic last_rdy;

  // Reference model: architectural view of register file and scoreboard.
  logic [31:0] m_rf    [32];
  bit          m_pend  [32];
  logic [3:0]  m_owner [32];
  logic [31:0] m_a, m_b, m_c;
  logic        m_exv;

  function automatic bit m_busy(input logic [4:0] r);
    return m_pend[r] && !(wb_valid_i && wb_rd_i == r);
  endfunction

  function automatic bit m_ready();
    case (id_instr_i)
      2'b00:   return !m_busy(id_rd_i);
      2'b01:   return !m_busy(id_rs2_i);
      2'b10:   return !m_busy(id_rs1_i) && !m_busy(id_rs2_i) && !m_busy(id_rd_i);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    return (wb_valid_i && wb_rd_i == r) ? wb_data_i : m_rf[r];
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0; m_pend[r] = 0; m_owner[r] = '0;
    end
    m_a = '0; m_b = '0; m_c = '0; m_exv = 1'b0;
  endtask

  task automatic m_clock(input bit iss);
    logic [31:0] a, b, c;
    a = '0; b = '0; c = '0;
    if (iss) begin
      if (id_instr_i == 2'b01) a = m_read(id_rs2_i);
      if (id_instr_i == 2'b10) begin
        a = m_read(id_rs1_i); b = m_read(id_rs2_i); c = m_read(id_rd_i);
      end
      m_a = a; m_b = b; m_c = c;
    end
    m_exv = iss;
    if (commit_valid_i && commit_kill_i)
      for (int r = 0; r < 32; r++)
        if (m_pend[r] && m_owner[r] == commit_id_i) m_pend[r] = 0;
    if (wb_valid_i) begin
      m_pend[wb_rd_i] = 0;
      m_rf[wb_rd_i] = wb_data_i;
    end
    if (iss && (id_instr_i == 2'b00 || id_instr_i == 2'b10)) begin
      m_pend[id_rd_i] = 1;
      m_owner[id_rd_i] = id_id_i;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [1:0] ins, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] id);
    id_valid_i = v; id_instr_i = ins; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_id_i = id;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid_i = v; wb_rd_i = rd; wb_data_i = d;
  endtask

  task automatic set_cm(input logic v, input logic [3:0] id, input logic k);
    commit_valid_i = v; commit_id_i = id; commit_kill_i = k;
  endtask

  task automatic idle();
    set_id(0, 2'b00, 0, 0, 0, 0); set_wb(0, 0, 0); set_cm(0, 0, 0);
  endtask

  // Called just after a negedge with inputs already driven; returns at the
  // next negedge after checking the registered outputs.
  task automatic step(input string tag);
    bit rdy, iss;
    #1;
    rdy = m_ready();
    last_rdy = id_ready_o;
    check({tag, ".ready"}, 32'(id_ready_o), 32'(rdy));
    iss = id_valid_i && rdy;
    @(posedge clk_i);
    m_clock(iss);
    #1;
    check({tag, ".exv"}, 32'(ex_valid_o), 32'(m_exv));
    check({tag, ".op_a"}, op_a_o, m_a);
    check({tag, ".op_b"}, op_b_o, m_b);
    check({tag, ".op_c"}, op_c_o, m_c);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_reset();
    #1;
    check("rst.exv", 32'(ex_valid_o), 32'(0));
    check("rst.op_a", op_a_o, 0);
    check("rst.op_b", op_b_o, 0);
    check("rst.op_c", op_c_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_reset();

    // DOTP on an all-zero register file.
    set_id(1, 2'b10, 1, 2, 3, 1); step("dotp0");
    check("dotp0.rdy_c", 32'(last_rdy), 1);
    check("dotp0.exv_c", 32'(ex_valid_o), 1);
    set_id(1, 2'b00, 0, 0, 3, 2); step("lw_r3_stall");
    check("lw_r3_stall.rdy_c", 32'(last_rdy), 0);
    idle(); set_wb(1, 3, 0); step("wb_r3");

    // RAW on LW rd=5 resolved by a same-cycle WB.
    set_id(1, 2'b00, 0, 0, 5, 2); step("lw_r5");
    set_id(1, 2'b10, 5, 0, 6, 3);
    for (int i = 0; i < 3; i++) begin
      step("raw_stall");
      check("raw_stall.rdy_c", 32'(last_rdy), 0);
    end
    set_wb(1, 5, 32'h0000_00AB); step("raw_fwd");
    check("raw_fwd.rdy_c", 32'(last_rdy), 1);
    check("raw_fwd.op_a_c", op_a_o, 32'hAB);
    idle(); set_wb(1, 6, 0); step("wb_r6");

    // WAW on r7.
    set_id(1, 2'b00, 0, 0, 7, 3); step("lw_r7a");
    set_id(1, 2'b00, 0, 0, 7, 5); step("waw_stall");
    check("waw_stall.rdy_c", 32'(last_rdy), 0);
    set_wb(1, 7, 32'h77); step("waw_issue");
    check("waw_issue.rdy_c", 32'(last_rdy), 1);
    idle(); set_id(1, 2'b01, 0, 7, 0, 0); step("r7_still_pending");
    check("r7_still_pending.rdy_c", 32'(last_rdy), 0);
    idle(); set_wb(1, 7, 0); step("wb_r7");

    // Kill releases a stalled store one cycle later.
    set_id(1, 2'b00, 0, 0, 9, 4); step("lw_r9");
    set_id(1, 2'b01, 0, 9, 0, 5); step("sw_r9_stall");
    set_cm(1, 4, 1); step("kill_cycle");
    check("kill_cycle.rdy_c", 32'(last_rdy), 0);
    set_cm(0, 0, 0); step("sw_after_kill");
    check("sw_after_kill.rdy_c", 32'(last_rdy), 1);
    check("sw_after_kill.op_a_c", op_a_o, 0);

    // Back-to-back issues.
    idle(); set_wb(1, 1, 3); step("wb_r1");
    set_wb(1, 2, 5); step("wb_r2");
    set_wb(1, 4, 10); step("wb_r4");
    idle(); set_id(1, 2'b01, 0, 1, 0, 0); step("b2b_sw1");
    check("b2b_sw1.op_a_c", op_a_o, 3);
    set_id(1, 2'b01, 0, 2, 0, 0); step("b2b_sw2");
    check("b2b_sw2.op_a_c", op_a_o, 5);
    set_id(1, 2'b10, 1, 2, 4, 6); step("b2b_dotp");
    check("b2b_dotp.ops_c", {op_a_o[7:0], op_b_o[7:0], op_c_o[7:0]}, 32'h03050A);
    check("b2b_dotp.exv_c", 32'(ex_valid_o), 1);
    idle(); set_wb(1, 4, 10); step("wb_r4b");

    // INVALID never issues.
    set_id(1, 2'b11, 1, 2, 3, 7); step("invalid");
    check("invalid.rdy_c", 32'(last_rdy), 0);
    check("invalid.exv_c", 32'(ex_valid_o), 0);

    // Reset in the middle of a stall.
    set_id(1, 2'b00, 0, 0, 10, 7); step("lw_r10");
    set_id(1, 2'b01, 0, 10, 0, 8); step("sw_r10_stall");
    check("sw_r10_stall.rdy_c", 32'(last_rdy), 0);
    do_reset();
    step("sw_r10_after_rst");
    check("sw_r10_after_rst.rdy_c", 32'(last_rdy), 1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (!(id_valid_i && !last_rdy)) begin
        set_id(($urandom % 4) != 0, 2'($urandom % 4), 5'($urandom % 8),
               5'($urandom % 8), 5'($urandom % 8), 4'($urandom % 16));
      end
      set_wb(($urandom % 3) == 0, 5'($urandom % 8), $urandom);
      set_cm(($urandom % 6) == 0, 4'($urandom % 16), 1'($urandom % 2));
      if (($urandom % 150) == 0) do_reset();
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
